// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   XLEN / INSTR_W     : address and instruction widths
//   RESET_PC_DEFAULT   : default PC loaded on reset
//   fetch_state_t      : fetch sequencer states (FETCH, WAIT, EXEC, FAULT)
//   pc_is_aligned()    : true when a PC is word aligned
package mips_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    function automatic logic pc_is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program-counter register.
//   clk   : system clock
//   rst_n : synchronous active-low reset, loads RESET_PC
//   load  : when high, q takes d on the rising edge
//   d     : next PC value
//   q     : current PC value
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer.
// Latches the committed next PC, fetches the word at that address over a
// request/response handshake, presents it to decode and returns pc+4 to the
// PC mux. A misaligned next PC at commit parks the unit in a sticky fault.
//   clk, rst_n          : clock, synchronous active-low reset
//   next_pc, stall      : commit inputs from the PC mux / downstream
//   pc, pc_plus4        : current PC and its successor (mod 2^32)
//   pc4_upper           : pc_plus4[31:28] for J-type targets
//   imem_req/addr/ready : fetch request channel
//   imem_rvalid/rdata   : fetch response channel
//   instr, instr_valid  : latched instruction and its validity
//   fault               : sticky misaligned-PC error
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XLEN-1:0]    next_pc,
    input  logic               stall,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic [3:0]         pc4_upper,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               fault
);

    fetch_state_t state;
    fetch_state_t state_next;

    // Cleared by reset, set by the first edge that samples rst_n high. The
    // reset edge already puts state in FETCH, so without this flag a request
    // would show while reset is still held.
    logic armed;

    logic pc_load;
    logic instr_load;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (next_pc),
        .q     (pc)
    );

    assign pc_plus4  = pc + 32'd4;
    assign pc4_upper = pc_plus4[31:28];
    assign imem_addr = pc;

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        instr_load = 1'b0;
        case (state)
            ST_FETCH: begin
                // rvalid without ready is a stale response and is ignored.
                if (armed && imem_ready) begin
                    if (imem_rvalid) begin
                        instr_load = 1'b1;
                        state_next = ST_EXEC;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    instr_load = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    if (pc_is_aligned(next_pc)) begin
                        pc_load    = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            armed <= 1'b0;
            instr <= '0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
            if (instr_load) begin
                instr <= imem_rdata;
            end
        end
    end

    // Moore outputs, decoded from registered state only.
    assign imem_req    = armed && (state == ST_FETCH);
    assign instr_valid = (state == ST_EXEC);
    assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] next_pc;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  pc4_upper;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the PC the unit should hold and the last instruction
    // it should have latched.
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    pc_fetch_unit #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .next_pc     (next_pc),
        .stall       (stall),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc4_upper   (pc4_upper),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks common to every cycle in which the unit should be in FETCH.
    task automatic check_fetch_state(input string tag);
        logic [31:0] p4;
        p4 = exp_pc + 32'd4;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL %s req: got %b want 1", tag, imem_req); end
        n_checks++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL %s addr: got %h want %h", tag, imem_addr, exp_pc); end
        n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", tag, pc, exp_pc); end
        n_checks++; if (pc_plus4 !== p4) begin n_fail++; $display("FAIL %s pc_plus4: got %h want %h", tag, pc_plus4, p4); end
        n_checks++; if (pc4_upper !== p4[31:28]) begin n_fail++; $display("FAIL %s pc4_upper: got %h want %h", tag, pc4_upper, p4[31:28]); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s instr_valid: got %b want 0", tag, instr_valid); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL %s fault: got %b want 0", tag, fault); end
        n_checks++; if (instr !== exp_instr) begin n_fail++; $display("FAIL %s instr: got %h want %h", tag, instr, exp_instr); end
    endtask

    // One full instruction: d stale-response cycles before accept, response
    // k cycles after accept, s stall cycles in EXEC, then commit of npc.
    // Entry and exit are both one cycle into FETCH (unless npc is misaligned).
    task automatic do_instr(input int k, input int s, input int d,
                            input logic [31:0] npc, input logic [31:0] data);
        check_fetch_state("fetch");
        for (int i = 0; i < d; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            stall       = 1'($urandom);
            step();
            check_fetch_state("stale");
        end
        imem_ready  = 1'b1;
        imem_rvalid = (k == 0);
        imem_rdata  = data;
        stall       = 1'($urandom);
        step();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        for (int i = 1; i <= k; i++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wait req: got %b want 0", imem_req); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait instr_valid: got %b want 0", instr_valid); end
            n_checks++; if (instr !== exp_instr) begin n_fail++; $display("FAIL wait instr: got %h want %h", instr, exp_instr); end
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL wait pc: got %h want %h", pc, exp_pc); end
            imem_rvalid = (i == k);
            imem_rdata  = data;
            stall       = 1'($urandom);
            step();
            imem_rvalid = 1'b0;
        end
        exp_instr = data;
        for (int j = 0; j <= s; j++) begin
            stall   = (j < s);
            next_pc = (j < s) ? $urandom : npc;
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL exec instr_valid: got %b want 1", instr_valid); end
            n_checks++; if (instr !== exp_instr) begin n_fail++; $display("FAIL exec instr: got %h want %h", instr, exp_instr); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL exec req: got %b want 0", imem_req); end
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL exec pc: got %h want %h", pc, exp_pc); end
            step();
        end
        stall = 1'b0;
        if (npc[1:0] == 2'b00) exp_pc = npc;
    endtask

    task automatic apply_reset(input int n);
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        repeat (n) step();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset req: got %b want 0", imem_req); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset fault: got %b want 0", fault); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset instr: got %h want 0", instr); end
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset pc: got %h want %h", pc, RST_PC); end
        rst_n = 1'b1;
        step();
        exp_pc    = RST_PC;
        exp_instr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        next_pc     = 32'h0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        repeat (3) step();
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", pc, RST_PC); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
        rst_n       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req_early: got %b want 0", imem_req); end
        step();
        exp_pc    = RST_PC;
        exp_instr = 32'h0;
        n_checks++; if (pc4_upper !== 4'h0) begin n_fail++; $display("FAIL rel_pc4_upper: got %h want 0", pc4_upper); end
        check_fetch_state("first_fetch");
    endtask

    task automatic test_zero_wait();
        logic [31:0] seq [3];
        seq[0] = 32'h0040_0000;
        seq[1] = 32'h0040_0004;
        seq[2] = 32'h0040_0008;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (pc !== seq[i]) begin n_fail++; $display("FAIL zw_pc%0d: got %h want %h", i, pc, seq[i]); end
            do_instr(0, 0, 0, exp_pc + 32'd4, exp_pc ^ 32'hA5A5_A5A5);
        end
    endtask

    task automatic test_wait_stall();
        do_instr(3, 4, 0, exp_pc + 32'd4, 32'h0BAD_F00D);
        check_fetch_state("after_stall");
    endtask

    task automatic test_jump_wrap();
        do_instr(1, 0, 0, 32'hFFFF_FFFC, 32'h1234_5678);
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_p4: got %h want 0", pc_plus4); end
        n_checks++; if (pc4_upper !== 4'h0) begin n_fail++; $display("FAIL wrap_upper: got %h want 0", pc4_upper); end
        do_instr(0, 1, 0, 32'h0123_4568, 32'h8765_4321);
        n_checks++; if (imem_addr !== 32'h0123_4568) begin n_fail++; $display("FAIL jump_addr: got %h want 01234568", imem_addr); end
        do_instr(2, 0, 1, 32'hF000_0000, 32'h0F0F_0F0F);
        n_checks++; if (pc4_upper !== 4'hF) begin n_fail++; $display("FAIL jump_upper: got %h want f", pc4_upper); end
    endtask

    task automatic test_misaligned();
        do_instr(0, 0, 0, 32'h0000_1002, 32'hCAFE_0001);
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL mis_fault: got %b want 1", fault); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req: got %b want 0", imem_req); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mis_valid: got %b want 0", instr_valid); end
            n_checks++; if (pc !== exp_pc) begin n_fail++; $display("FAIL mis_pc: got %h want %h", pc, exp_pc); end
            imem_ready  = 1'($urandom);
            imem_rvalid = 1'($urandom);
            stall       = 1'($urandom);
            next_pc     = $urandom & 32'hFFFF_FFFC;
            step();
        end
        apply_reset(1);
        check_fetch_state("mis_recover");
    endtask

    task automatic test_reset_mid_wait();
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        step();
        imem_ready  = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mw_wait_req: got %b want 0", imem_req); end
        rst_n       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        rst_n = 1'b1;
        step();
        exp_pc    = RST_PC;
        exp_instr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            imem_ready  = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL mw_instr: got %h want 0", instr); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mw_valid: got %b want 0", instr_valid); end
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL mw_req: got %b want 1", imem_req); end
            step();
        end
        imem_rvalid = 1'b0;
        do_instr(1, 0, 0, exp_pc + 32'd4, 32'h5555_AAAA);
    endtask

    task automatic test_random();
        logic [31:0] npc;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) npc = $urandom & 32'hFFFF_FFFC;
            else npc = exp_pc + 32'd4;
            do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 2)), npc, $urandom);
        end
        check_fetch_state("rand_end");
    endtask

    initial begin
        exp_pc    = RST_PC;
        exp_instr = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_stall();
        test_jump_wrap();
        test_misaligned();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
